// File: rtl/cell_draw_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cell_draw_controller                                         |
// | Description : Sequences box-draw and screen-clear pixel writes to the VGA  |
// |               frame-buffer adapter, one registered plot per clock.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cell_draw_controller #(
   parameter int BOX_W = 8,
   parameter int BOX_H = 3,
   parameter int SCR_W = 160,
   parameter int SCR_H = 120
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_x,
   input  logic [7:0] req_y,
   input  logic [2:0] req_colour,
   input  logic       req_fill,
   input  logic       clr_req,
   output logic       busy,
   output logic       done,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       plot
);

   localparam logic [7:0] c_BOX_W_LAST = 8'(BOX_W - 1);
   localparam logic [7:0] c_BOX_H_LAST = 8'(BOX_H - 1);
   localparam logic [7:0] c_SCR_W_LAST = 8'(SCR_W - 1);
   localparam logic [7:0] c_SCR_H_LAST = 8'(SCR_H - 1);
   localparam logic [8:0] c_SCR_W9     = 9'(SCR_W);
   localparam logic [8:0] c_SCR_H9     = 9'(SCR_H);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAW  = 2'd1,
      S_CLEAR = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_clr_pending;
   logic [7:0] r_x0;
   logic [7:0] r_y0;
   logic [2:0] r_colour;
   logic       r_fill;
   logic [7:0] r_dx;
   logic [7:0] r_dy;

   logic       w_clr_any;
   logic [7:0] w_x_last;
   logic [7:0] w_y_last;
   logic       w_dx_end;
   logic       w_last;
   logic [8:0] w_px;
   logic [8:0] w_py;
   logic       w_inb;
   logic       w_border;

   // A clear request arriving in the same cycle as a box request must win,
   // so the live clr_req is folded in alongside the pending flag; this keeps
   // req_ready low whenever the controller is about to start a clear.
   assign w_clr_any = (r_state != S_CLEAR) && (r_clr_pending || clr_req);
   assign req_ready = (r_state == S_IDLE) && !w_clr_any;
   assign busy      = (r_state != S_IDLE);

   // The scan counters are shared between box draw and screen clear.
   assign w_x_last = (r_state == S_CLEAR) ? c_SCR_W_LAST : c_BOX_W_LAST;
   assign w_y_last = (r_state == S_CLEAR) ? c_SCR_H_LAST : c_BOX_H_LAST;
   assign w_dx_end = (r_dx == w_x_last);
   assign w_last   = w_dx_end && (r_dy == w_y_last);

   // Pixel position at 9 bits so boxes near the right/bottom edge clip
   // instead of wrapping around to the opposite side.
   assign w_px     = {1'b0, r_x0} + {1'b0, r_dx};
   assign w_py     = {1'b0, r_y0} + {1'b0, r_dy};
   assign w_inb    = (w_px < c_SCR_W9) && (w_py < c_SCR_H9);
   assign w_border = r_fill || (r_dx == 8'd0) || (r_dx == c_BOX_W_LAST)
                     || (r_dy == 8'd0) || (r_dy == c_BOX_H_LAST);

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic: clear has priority over a box request in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_clr_any)      w_state_nxt = S_CLEAR;
            else if (req_valid) w_state_nxt = S_DRAW;
         end
         S_DRAW:  if (w_last) w_state_nxt = S_IDLE;
         S_CLEAR: if (w_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Remember a clear request until IDLE can start it; ignored while clearing.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                          r_clr_pending <= 1'b0;
      else if (r_state == S_IDLE && w_clr_any) r_clr_pending <= 1'b0;
      else if (clr_req && r_state != S_CLEAR)  r_clr_pending <= 1'b1;
   end

   // Request latch, raster counters and registered adapter outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_x0       <= 8'd0;
         r_y0       <= 8'd0;
         r_colour   <= 3'd0;
         r_fill     <= 1'b0;
         r_dx       <= 8'd0;
         r_dy       <= 8'd0;
         vga_x      <= 8'd0;
         vga_y      <= 7'd0;
         vga_colour <= 3'd0;
         plot       <= 1'b0;
         done       <= 1'b0;
      end else begin
         plot <= 1'b0;
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_dx <= 8'd0;
               r_dy <= 8'd0;
               if (!w_clr_any && req_valid) begin
                  r_x0     <= req_x;
                  r_y0     <= req_y;
                  r_colour <= req_colour;
                  r_fill   <= req_fill;
               end
            end
            S_DRAW, S_CLEAR: begin
               if (r_state == S_DRAW) begin
                  vga_x      <= w_px[7:0];
                  vga_y      <= w_py[6:0];
                  vga_colour <= r_colour;
                  plot       <= w_inb && w_border;
               end else begin
                  vga_x      <= r_dx;
                  vga_y      <= r_dy[6:0];
                  vga_colour <= 3'd0;
                  plot       <= 1'b1;
               end
               if (w_last) begin
                  done <= 1'b1;
               end else if (w_dx_end) begin
                  r_dx <= 8'd0;
                  r_dy <= r_dy + 8'd1;
               end else begin
                  r_dx <= r_dx + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cell_draw_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cell_draw_controller                                      |
// | Description : Self-checking bench for cell_draw_controller.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cell_draw_controller;

   logic       clk = 1'b0;
   logic       resetn;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_x;
   logic [7:0] req_y;
   logic [2:0] req_colour;
   logic       req_fill;
   logic       clr_req;
   logic       busy;
   logic       done;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       plot;

   int tests = 0;
   int fails = 0;

   cell_draw_controller dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_colour (req_colour),
      .req_fill   (req_fill),
      .clr_req    (clr_req),
      .busy       (busy),
      .done       (done),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .plot       (plot)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic [2:0] col;
      logic       fill;
      int         exp_plots;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Called at the negedge right after the accept edge; follows 24 pixels.
   task automatic draw_check(input vec_t v, input string tag);
      int nplot = 0, perr = 0, dones = 0, done_last = 0;
      chk({tag, "_busy"}, int'(busy), 1);
      for (int k = 0; k < 24; k++) begin
         int dx = k % 8, dy = k / 8;
         int px = int'(v.x) + dx, py = int'(v.y) + dy;
         logic inb  = (px < 160) && (py < 120);
         logic bord = v.fill || dx == 0 || dx == 7 || dy == 0 || dy == 2;
         logic ep   = inb && bord;
         @(negedge clk);
         if (plot !== ep) perr++;
         if (ep && (vga_x !== 8'(px) || vga_y !== 7'(py) || vga_colour !== v.col)) perr++;
         if (plot === 1'b1) nplot++;
         if (done === 1'b1) begin
            dones++;
            if (k == 23) done_last = 1;
         end
         if (k == 0) req_x = 8'hAA;
      end
      chk({tag, "_pixel_errs"}, perr, 0);
      chk({tag, "_plots"}, nplot, v.exp_plots);
      chk({tag, "_done_last"}, done_last, 1);
      chk({tag, "_done_cnt"}, dones, 1);
      chk({tag, "_ready_after"}, int'(req_ready), 1);
      chk({tag, "_busy_after"}, int'(busy), 0);
      @(negedge clk);
      chk({tag, "_plot_idle"}, int'(plot), 0);
   endtask

   task automatic run_box(input vec_t v, input string tag);
      @(negedge clk);
      req_x = v.x; req_y = v.y; req_colour = v.col; req_fill = v.fill;
      req_valid = 1'b1;
      #1 chk({tag, "_ready_before"}, int'(req_ready), 1);
      @(negedge clk);
      req_valid = 1'b0;
      req_y = 8'h55; req_colour = ~v.col; req_fill = ~v.fill;
      draw_check(v, tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones, bad_ready, black, boxp, c, first_done, second_done;
      int lx, ly;
      vecs[0] = '{8'd20,  8'd30,  3'b100, 1'b1, 24};
      vecs[1] = '{8'd20,  8'd30,  3'b100, 1'b0, 18};
      vecs[2] = '{8'd155, 8'd118, 3'b010, 1'b1, 10};
      vecs[3] = '{8'd155, 8'd118, 3'b011, 1'b0, 6};
      vecs[4] = '{8'd0,   8'd0,   3'b010, 1'b0, 18};
      vecs[5] = '{8'd152, 8'd0,   3'b111, 1'b1, 24};
      vecs[6] = '{8'd159, 8'd119, 3'b001, 1'b1, 1};
      vecs[7] = '{8'd200, 8'd50,  3'b101, 1'b1, 0};

      resetn = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0;
      req_colour = '0; req_fill = 1'b0; clr_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_plot", int'(plot), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_vga_x", int'(vga_x), 0);
      chk("rst_vga_colour", int'(vga_colour), 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_ready", int'(req_ready), 1);

      foreach (vecs[i]) run_box(vecs[i], $sformatf("vec%0d", i));

      // Clear pulse mid-draw: box finishes, then a full black clear.
      @(negedge clk);
      req_x = 8'd20; req_y = 8'd30; req_colour = 3'b100; req_fill = 1'b1;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      dones = 0; bad_ready = 0; black = 0; boxp = 0; first_done = -1; second_done = -1;
      lx = -1; ly = -1;
      for (c = 0; c < 25000 && dones < 2; c++) begin
         @(negedge clk);
         if (plot === 1'b1 && vga_colour === 3'b000) black++;
         if (plot === 1'b1 && vga_colour === 3'b100) boxp++;
         if (done === 1'b1) begin
            dones++;
            if (dones == 1) first_done = c;
            if (dones == 2) begin second_done = c; lx = int'(vga_x); ly = int'(vga_y); end
         end
         if (dones < 2 && req_ready !== 1'b0) bad_ready++;
         clr_req = (c == 5);
      end
      clr_req = 1'b0;
      chk("mid_clr_done_cnt", dones, 2);
      chk("mid_clr_box_plots", boxp, 24);
      chk("mid_clr_black_plots", black, 19200);
      chk("mid_clr_first_done", first_done, 23);
      chk("mid_clr_second_done", second_done, 19224);
      chk("mid_clr_last_x", lx, 159);
      chk("mid_clr_last_y", ly, 119);
      chk("mid_clr_ready_low", bad_ready, 0);
      chk("mid_clr_ready_after", int'(req_ready), 1);

      // Clear and box request in the same cycle: clear first, then the box.
      @(negedge clk);
      req_x = 8'd40; req_y = 8'd50; req_colour = 3'b011; req_fill = 1'b1;
      req_valid = 1'b1; clr_req = 1'b1;
      #1 chk("tie_ready_low", int'(req_ready), 0);
      @(negedge clk);
      clr_req = 1'b0;
      dones = 0; bad_ready = 0; black = 0; boxp = 0; first_done = -1;
      for (c = 0; c < 25000 && dones < 1; c++) begin
         @(negedge clk);
         if (plot === 1'b1 && vga_colour === 3'b000) black++;
         if (plot === 1'b1 && vga_colour !== 3'b000) boxp++;
         if (done === 1'b1) begin dones++; first_done = c; end
         if (dones < 1 && req_ready !== 1'b0) bad_ready++;
         clr_req = (c == 100);
      end
      clr_req = 1'b0;
      chk("tie_clear_done", first_done, 19199);
      chk("tie_black_plots", black, 19200);
      chk("tie_no_box_first", boxp, 0);
      chk("tie_ready_low_during", bad_ready, 0);
      chk("tie_ready_after_clear", int'(req_ready), 1);
      @(negedge clk);
      req_valid = 1'b0;
      draw_check('{8'd40, 8'd50, 3'b011, 1'b1, 24}, "tie_box");

      // Reset mid-draw aborts immediately; next request starts afresh.
      @(negedge clk);
      req_x = 8'd20; req_y = 8'd30; req_colour = 3'b100; req_fill = 1'b1;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("abort_plot", int'(plot), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_vga_x", int'(vga_x), 0);
      @(negedge clk);
      resetn = 1'b1;
      run_box(vecs[0], "post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
